// File: rtl/branch_condition_unit.sv
// Branch condition unit: accepts a conditional branch, waits until every
// in-flight flag-setting op has retired, evaluates the condition code against
// the architectural flags, and on a taken branch flushes the pipeline and
// hands a redirect PC to fetch.
module branch_condition_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  flags,
  input  logic        flags_reg_write_enable,
  input  logic        flag_op_issue,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [15:0] br_target,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        stall,
  output logic [15:0] taken_count
);

  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned COND_W   = 4;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PEND_W   = 3;
  localparam int unsigned PEND_MAX = 7;

  // Flag bit positions inside the flags word
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Condition code encodings
  localparam logic [COND_W-1:0] COND_EQ = COND_W'(0);
  localparam logic [COND_W-1:0] COND_NE = COND_W'(1);
  localparam logic [COND_W-1:0] COND_CS = COND_W'(2);
  localparam logic [COND_W-1:0] COND_CC = COND_W'(3);
  localparam logic [COND_W-1:0] COND_MI = COND_W'(4);
  localparam logic [COND_W-1:0] COND_PL = COND_W'(5);
  localparam logic [COND_W-1:0] COND_VS = COND_W'(6);
  localparam logic [COND_W-1:0] COND_VC = COND_W'(7);
  localparam logic [COND_W-1:0] COND_HI = COND_W'(8);
  localparam logic [COND_W-1:0] COND_LS = COND_W'(9);
  localparam logic [COND_W-1:0] COND_GE = COND_W'(10);
  localparam logic [COND_W-1:0] COND_LT = COND_W'(11);
  localparam logic [COND_W-1:0] COND_GT = COND_W'(12);
  localparam logic [COND_W-1:0] COND_LE = COND_W'(13);
  localparam logic [COND_W-1:0] COND_AL = COND_W'(14);
  localparam logic [COND_W-1:0] COND_NV = COND_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_EVAL       = 2'd2,
    ST_REDIRECT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [COND_W-1:0]   cond_q, cond_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                br_ready_q;
  logic                redirect_valid_q;
  logic                stall_q;
  logic                cond_true;

  // Evaluate a condition code against an NZCV flags word
  function automatic logic cond_met(input logic [COND_W-1:0] cond,
                                    input logic [FLAGS_W-1:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_met = z;
      COND_NE: cond_met = !z;
      COND_CS: cond_met = c;
      COND_CC: cond_met = !c;
      COND_MI: cond_met = n;
      COND_PL: cond_met = !n;
      COND_VS: cond_met = v;
      COND_VC: cond_met = !v;
      COND_HI: cond_met = c && !z;
      COND_LS: cond_met = !c || z;
      COND_GE: cond_met = (n == v);
      COND_LT: cond_met = (n != v);
      COND_GT: cond_met = !z && (n == v);
      COND_LE: cond_met = z || (n != v);
      COND_AL: cond_met = 1'b1;
      COND_NV: cond_met = 1'b0;
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign cond_true = cond_met(cond_q, flags);

  // Saturating count of flag-setting ops issued but not yet retired
  always_comb begin
    pend_d = pend_q;
    if (flag_op_issue && !flags_reg_write_enable) begin
      if (pend_q != PEND_W'(PEND_MAX)) begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (flags_reg_write_enable && !flag_op_issue) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1);
      end
    end
  end

  // Next-state, branch capture, taken counter and the combinational flush pulse
  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    flush    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond;
          target_d = br_target;
          state_d  = (pend_d != '0) ? ST_WAIT_FLAGS : ST_EVAL;
        end
      end
      ST_WAIT_FLAGS: begin
        // Leave once the last outstanding flag write retires this cycle
        if (pend_d == '0) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (cond_true) begin
          flush   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      pend_q           <= '0;
      cond_q           <= '0;
      target_q         <= '0;
      cnt_q            <= '0;
      br_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      stall_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_q           <= pend_d;
      cond_q           <= cond_d;
      target_q         <= target_d;
      cnt_q            <= cnt_d;
      br_ready_q       <= (state_d == ST_IDLE);
      redirect_valid_q <= (state_d == ST_REDIRECT);
      stall_q          <= (state_d == ST_WAIT_FLAGS);
    end
  end

  assign br_ready       = br_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;
  assign stall          = stall_q;
  assign taken_count    = cnt_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed bench for branch_condition_unit: condition table sweep plus
// hand-written stall, backpressure, reset-abort and saturation sequences.
module tb_branch_condition_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  flags;
  logic        flags_reg_write_enable;
  logic        flag_op_issue;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [15:0] br_target;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [15:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic [15:0] taken_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt;

  // One record per condition code: bit f of mask set when flags==f is taken
  typedef struct {
    logic [3:0]  cond;
    logic [15:0] mask;
  } cond_vec_t;

  cond_vec_t tbl [16];

  branch_condition_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .flags                  (flags),
    .flags_reg_write_enable (flags_reg_write_enable),
    .flag_op_issue          (flag_op_issue),
    .br_valid               (br_valid),
    .br_ready               (br_ready),
    .br_cond                (br_cond),
    .br_target              (br_target),
    .redirect_valid         (redirect_valid),
    .redirect_ready         (redirect_ready),
    .redirect_pc            (redirect_pc),
    .flush                  (flush),
    .stall                  (stall),
    .taken_count            (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h want 0x%04h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Single branch from IDLE with pending 0 and redirect_ready held high
  task automatic run_branch(input logic [3:0] cond, input logic [3:0] fl,
                            input logic [15:0] target, input logic exp_taken,
                            input string name);
    flags          = fl;
    br_cond        = cond;
    br_target      = target;
    br_valid       = 1'b1;
    redirect_ready = 1'b1;
    @(negedge clk);
    chk1({name, " br_ready@N"}, br_ready, 1'b1);
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    chk1({name, " flush@N+1"}, flush, exp_taken);
    chk1({name, " stall@N+1"}, stall, 1'b0);
    if (exp_taken) exp_cnt = exp_cnt + 16'd1;
    next_cycle();
    @(negedge clk);
    if (exp_taken) begin
      chk1({name, " redirect_valid@N+2"}, redirect_valid, 1'b1);
      chk16({name, " redirect_pc@N+2"}, redirect_pc, target);
      next_cycle();
      @(negedge clk);
    end
    chk1({name, " br_ready back"}, br_ready, 1'b1);
    chk1({name, " redirect_valid low"}, redirect_valid, 1'b0);
    chk16({name, " taken_count"}, taken_count, exp_cnt);
    next_cycle();
  endtask

  initial begin
    tbl[0]  = '{4'd0,  16'hF0F0};
    tbl[1]  = '{4'd1,  16'h0F0F};
    tbl[2]  = '{4'd2,  16'hCCCC};
    tbl[3]  = '{4'd3,  16'h3333};
    tbl[4]  = '{4'd4,  16'hFF00};
    tbl[5]  = '{4'd5,  16'h00FF};
    tbl[6]  = '{4'd6,  16'hAAAA};
    tbl[7]  = '{4'd7,  16'h5555};
    tbl[8]  = '{4'd8,  16'h0C0C};
    tbl[9]  = '{4'd9,  16'hF3F3};
    tbl[10] = '{4'd10, 16'hAA55};
    tbl[11] = '{4'd11, 16'h55AA};
    tbl[12] = '{4'd12, 16'h0A05};
    tbl[13] = '{4'd13, 16'hF5FA};
    tbl[14] = '{4'd14, 16'hFFFF};
    tbl[15] = '{4'd15, 16'h0000};

    rst                    = 1'b1;
    flags                  = 4'h0;
    flags_reg_write_enable = 1'b0;
    flag_op_issue          = 1'b0;
    br_valid               = 1'b0;
    br_cond                = 4'h0;
    br_target              = 16'h0000;
    redirect_ready         = 1'b0;
    exp_cnt                = 16'h0000;

    // Reset values
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk1("rst br_ready", br_ready, 1'b1);
    chk1("rst redirect_valid", redirect_valid, 1'b0);
    chk1("rst stall", stall, 1'b0);
    chk1("rst flush", flush, 1'b0);
    chk16("rst taken_count", taken_count, 16'h0000);
    chk16("rst redirect_pc", redirect_pc, 16'h0000);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk1("release br_ready", br_ready, 1'b1);
    next_cycle();

    // Basic taken and not-taken EQ branches
    run_branch(4'd0, 4'b0100, 16'h1234, 1'b1, "eq_taken");
    run_branch(4'd0, 4'b0000, 16'h5678, 1'b0, "eq_not_taken");

    // Two flag ops in flight: stall until both writes retire, then use new flags
    flags         = 4'b0000;
    flag_op_issue = 1'b1;
    next_cycle();
    next_cycle();
    flag_op_issue  = 1'b0;
    br_valid       = 1'b1;
    br_cond        = 4'd0;
    br_target      = 16'hBEEF;
    redirect_ready = 1'b1;
    @(negedge clk);
    chk1("pend2 br_ready@N", br_ready, 1'b1);
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    chk1("pend2 stall c1", stall, 1'b1);
    chk1("pend2 br_ready c1", br_ready, 1'b0);
    chk1("pend2 flush c1", flush, 1'b0);
    flags_reg_write_enable = 1'b1;
    next_cycle();
    flags_reg_write_enable = 1'b0;
    @(negedge clk);
    chk1("pend2 stall c2", stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("pend2 stall c3", stall, 1'b1);
    flags_reg_write_enable = 1'b1;
    next_cycle();
    flags_reg_write_enable = 1'b0;
    flags                  = 4'b0100;
    @(negedge clk);
    chk1("pend2 stall eval", stall, 1'b0);
    chk1("pend2 flush eval", flush, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    next_cycle();
    @(negedge clk);
    chk1("pend2 redirect_valid", redirect_valid, 1'b1);
    chk16("pend2 redirect_pc", redirect_pc, 16'hBEEF);
    next_cycle();
    @(negedge clk);
    chk1("pend2 br_ready after", br_ready, 1'b1);
    chk16("pend2 taken_count", taken_count, exp_cnt);
    next_cycle();

    // Redirect backpressure: held stable for five cycles
    br_valid       = 1'b1;
    br_cond        = 4'd14;
    br_target      = 16'h0F0F;
    redirect_ready = 1'b0;
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    chk1("bp flush", flush, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("bp redirect_valid c%0d", i), redirect_valid, 1'b1);
      chk16($sformatf("bp redirect_pc c%0d", i), redirect_pc, 16'h0F0F);
      chk1($sformatf("bp br_ready c%0d", i), br_ready, 1'b0);
      next_cycle();
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    chk1("bp redirect_valid accept", redirect_valid, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("bp redirect_valid done", redirect_valid, 1'b0);
    chk1("bp br_ready done", br_ready, 1'b1);
    chk16("bp taken_count", taken_count, exp_cnt);
    next_cycle();

    // Reset during REDIRECT aborts the branch and clears the count
    br_valid       = 1'b1;
    br_cond        = 4'd14;
    br_target      = 16'h4321;
    redirect_ready = 1'b0;
    next_cycle();
    br_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk1("rstredir redirect_valid", redirect_valid, 1'b1);
    chk16("rstredir count before", taken_count, exp_cnt);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_cnt = 16'h0000;
    @(negedge clk);
    chk1("rstredir redirect_valid after", redirect_valid, 1'b0);
    chk16("rstredir taken_count after", taken_count, 16'h0000);
    chk1("rstredir br_ready after", br_ready, 1'b1);
    chk16("rstredir redirect_pc after", redirect_pc, 16'h0000);
    next_cycle();

    // Reset during WAIT_FLAGS aborts and clears the pending count
    flag_op_issue = 1'b1;
    next_cycle();
    flag_op_issue = 1'b0;
    br_valid      = 1'b1;
    br_cond       = 4'd14;
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    chk1("rstwait stall", stall, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk1("rstwait stall after", stall, 1'b0);
    next_cycle();
    redirect_ready = 1'b1;
    run_branch(4'd14, 4'b0000, 16'h2222, 1'b1, "post_rstwait");

    // Eight issues saturate at 7; six writes leave one outstanding
    flag_op_issue = 1'b1;
    repeat (8) next_cycle();
    flag_op_issue          = 1'b0;
    flags_reg_write_enable = 1'b1;
    repeat (6) next_cycle();
    flags_reg_write_enable = 1'b0;
    br_valid  = 1'b1;
    br_cond   = 4'd14;
    br_target = 16'h7777;
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    chk1("sat stall", stall, 1'b1);
    chk1("sat flush", flush, 1'b0);
    flags_reg_write_enable = 1'b1;
    next_cycle();
    flags_reg_write_enable = 1'b0;
    @(negedge clk);
    chk1("sat stall released", stall, 1'b0);
    chk1("sat flush eval", flush, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    next_cycle();
    @(negedge clk);
    chk16("sat redirect_pc", redirect_pc, 16'h7777);
    next_cycle();

    // All 16 conditions against all 16 flag values
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic t;
        t = tbl[c].mask[f];
        run_branch(tbl[c].cond, 4'(f), 16'(32'hA000 + c * 16 + f), t,
                   $sformatf("cond%0d_f%0h", c, f));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_condition_unit.md
BRANCH_CONDITION_UNIT -- requirements
Module: branch_condition_unit

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port flags, input, 4, current flags register output; bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
REQ-004 SHALL have port flags_reg_write_enable, input, 1, flags register written this cycle (retirement of a flag-setting op).
REQ-005 SHALL have port flag_op_issue, input, 1, flag-setting op entered pipeline this cycle.
REQ-006 SHALL have port br_valid, input, 1, branch request offered.
REQ-007 SHALL have port br_ready, output, 1, unit accepts branch request.
REQ-008 SHALL have port br_cond, input, 4, condition code.
REQ-009 SHALL have port br_target, input, 16, branch target address.
REQ-010 SHALL have port redirect_valid, output, 1, PC redirect offered to fetch.
REQ-011 SHALL have port redirect_ready, input, 1, fetch accepts redirect.
REQ-012 SHALL have port redirect_pc, output, 16, redirect address.
REQ-013 SHALL have port flush, output, 1, single-cycle pipeline flush pulse.
REQ-014 SHALL have port stall, output, 1, branch waiting on in-flight flag writes.
REQ-015 SHALL have port taken_count, output, 16, count of taken branches.

Function
REQ-016 SHALL keep 3-bit pending counter: +1 on flag_op_issue only, -1 on flags_reg_write_enable only, unchanged when both or neither; saturates at 7 (increment ignored) and 0 (decrement ignored).
REQ-017 SHALL implement FSM states IDLE, WAIT_FLAGS, EVAL, REDIRECT.
REQ-018 br_ready SHALL be 1 only in IDLE; handshake completes when br_valid and br_ready both 1.
REQ-019 On handshake SHALL latch br_cond and br_target; next state WAIT_FLAGS if next-cycle pending count nonzero, else EVAL.
REQ-020 WAIT_FLAGS SHALL assert stall and move to EVAL in the cycle after pending count reaches 0.
REQ-021 EVAL SHALL evaluate latched condition against flags that cycle: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-022 EVAL taken: flush = 1 for that cycle only, taken_count +1 (wraps 0xFFFF -> 0x0000), next REDIRECT; not taken: flush 0, next IDLE.
REQ-023 REDIRECT SHALL drive redirect_valid = 1 with redirect_pc = latched target, both held stable until redirect_ready = 1, then next IDLE.
REQ-024 Latency with pending 0: handshake cycle N, EVAL N+1, redirect_valid first high N+2.
REQ-025 redirect_valid SHALL be 0 outside REDIRECT; stall SHALL be 0 outside WAIT_FLAGS.
REQ-026 Pending counter SHALL keep updating in every state.

Reset
REQ-027 When rst = 1 at a rising edge: state IDLE, pending 0, taken_count 0, redirect_pc 0x0000, redirect_valid 0, flush 0, stall 0, latched cond/target cleared.
REQ-028 Reset in any state (incl. mid-REDIRECT or WAIT_FLAGS) SHALL abort the branch; redirect_valid 0 from the next cycle, no taken_count update.
REQ-029 br_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-030 pending 0, flags Z=1, br_cond 0, br_target 0x1234, redirect_ready 1 -> flush pulse at N+1, redirect_valid/redirect_pc 0x1234 at N+2, taken_count 1, back to IDLE at N+3.
REQ-031 flags 0000, br_cond 0 (EQ) -> no flush, no redirect, br_ready 1 again at N+2, taken_count unchanged.
REQ-032 two flag_op_issue pulses then branch -> stall high until two flags_reg_write_enable pulses seen; EVAL uses flags after the second write.
REQ-033 taken branch with redirect_ready low 5 cycles -> redirect_valid and redirect_pc stable all 5 cycles, br_ready 0 throughout.
REQ-034 rst asserted during REDIRECT -> redirect_valid 0 and taken_count 0 next cycle; also 8 issues with no writes -> pending saturates at 7.
REQ-035 all 16 conditions against all 16 flag values -> taken matches REQ-021 table.
